// File: rtl/nasti_stream_writer.sv
// nasti_stream_writer: moves an AXI-stream of DATA_WIDTH words into memory
// through the NASTI AW/W/B channels, one INCR burst at a time.
// The stream and NASTI interfaces are flattened into src_* and dest_* ports.
module nasti_stream_writer #(
  parameter int ADDR_WIDTH       = 64,
  parameter int DATA_WIDTH       = 64,
  parameter int MAX_BURST_LENGTH = 8
) (
  input  logic                    aclk,
  input  logic                    areset,
  // stream slave
  input  logic                    src_t_valid,
  output logic                    src_t_ready,
  input  logic [DATA_WIDTH-1:0]   src_t_data,
  input  logic [DATA_WIDTH/8-1:0] src_t_strb,
  input  logic [DATA_WIDTH/8-1:0] src_t_keep,
  input  logic                    src_t_last,
  // NASTI master, write side only
  output logic                    dest_aw_valid,
  input  logic                    dest_aw_ready,
  output logic [3:0]              dest_aw_id,
  output logic [ADDR_WIDTH-1:0]   dest_aw_addr,
  output logic [7:0]              dest_aw_len,
  output logic [2:0]              dest_aw_size,
  output logic [1:0]              dest_aw_burst,
  output logic                    dest_aw_lock,
  output logic [3:0]              dest_aw_cache,
  output logic [2:0]              dest_aw_prot,
  output logic                    dest_w_valid,
  input  logic                    dest_w_ready,
  output logic [DATA_WIDTH-1:0]   dest_w_data,
  output logic [DATA_WIDTH/8-1:0] dest_w_strb,
  output logic                    dest_w_last,
  output logic                    dest_w_user,
  input  logic                    dest_b_valid,
  output logic                    dest_b_ready,
  input  logic [1:0]              dest_b_resp,
  // request port
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [ADDR_WIDTH-1:0]   req_len,
  input  logic                    req_valid,
  output logic                    req_ready,
  output logic                    req_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BYTES - 1));

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   len_q;       // bytes still to be issued as bursts
  logic [8:0]              beats_q;     // beats in the burst now in flight
  logic [8:0]              beat_cnt_q;  // handshaken beats of that burst
  logic                    err_q;

  logic [ADDR_WIDTH-1:0]   len_beats;
  logic [8:0]              burst_beats;
  logic [ADDR_WIDTH-1:0]   burst_bytes;
  logic                    w_hs;
  logic                    last_beat;
  logic                    final_beat;
  logic                    unused_keep;

  // t_keep carries no information for a plain memory write
  assign unused_keep = ^src_t_keep;

  // Size of the next burst: whatever is left, capped at MAX_BURST_LENGTH
  always_comb begin
    len_beats = len_q >> SIZE;
    if (len_beats > ADDR_WIDTH'(MAX_BURST_LENGTH)) begin
      burst_beats = 9'(MAX_BURST_LENGTH);
    end else begin
      burst_beats = len_beats[8:0];
    end
    burst_bytes = ADDR_WIDTH'(burst_beats) << SIZE;
  end

  assign last_beat  = (state_q == S_DATA) && (beat_cnt_q == beats_q - 9'd1);
  // len_q was already reduced at the AW handshake, so zero means this is the
  // request's closing burst
  assign final_beat = last_beat && (len_q == '0);
  assign w_hs       = (state_q == S_DATA) && src_t_valid && dest_w_ready;

  assign req_ready     = (state_q == S_IDLE);
  assign req_err       = err_q;

  assign dest_aw_valid = (state_q == S_ADDR) && (len_q != '0);
  assign dest_aw_id    = 4'd0;
  assign dest_aw_addr  = addr_q;
  assign dest_aw_len   = 8'(burst_beats - 9'd1);
  assign dest_aw_size  = 3'(SIZE);
  assign dest_aw_burst = 2'b01;
  assign dest_aw_lock  = 1'b0;
  assign dest_aw_cache = 4'd0;
  assign dest_aw_prot  = 3'd0;

  // W is a straight pass-through of the stream while a burst is open
  assign dest_w_valid  = (state_q == S_DATA) && src_t_valid;
  assign dest_w_data   = src_t_data;
  assign dest_w_strb   = src_t_strb;
  assign dest_w_last   = last_beat;
  assign dest_w_user   = 1'b0;
  assign src_t_ready   = (state_q == S_DATA) && dest_w_ready;

  assign dest_b_ready  = (state_q == S_RESP);

  // Request sequencing: one burst issued, streamed and acknowledged at a time
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr & ALIGN_MASK;
            len_q   <= req_len & ALIGN_MASK;
            err_q   <= 1'b0;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (len_q == '0) begin
            state_q <= S_IDLE;
          end else if (dest_aw_ready) begin
            addr_q     <= addr_q + burst_bytes;
            len_q      <= len_q - burst_bytes;
            beats_q    <= burst_beats;
            beat_cnt_q <= '0;
            state_q    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
            if (src_t_last && !final_beat) begin
              err_q <= 1'b1;
            end
            if (last_beat) begin
              state_q <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (dest_b_valid) begin
            if (dest_b_resp != 2'b00) begin
              err_q <= 1'b1;
            end
            state_q <= S_ADDR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
